dmp_domain_ctrl: RTL

//  Upstream control stage for the PMP/DMP checker: owns the DMP configuration array and the current domain

---
 rtl/dmp_domain_ctrl_pkg.sv | 28 ++
 rtl/riscv_pkg.sv | 21 ++
 rtl/dmp_domain_ctrl_if.sv | 30 +++
 rtl/dmp_outstanding_cnt.sv | 47 ++++
 rtl/dmp_domain_ctrl.sv | 133 +++++++++++++
 5 files changed

// File: rtl/dmp_domain_ctrl_pkg.sv
// Shared definitions for the DMP domain control stage: FSM states, reset
// value of a config entry and the switch legality rule.
package dmp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        COMMIT = 3'd2,
        ACK    = 3'd3,
        ERR    = 3'd4
    } state_e;

    localparam riscv::dmpcfg_t DMP_RST_ENTRY = '{domain: riscv::DOMI, locked: 1'b0};

    // M-mode may switch to any valid domain; lower privileges may only
    // narrow to a subset of the domains they currently hold.
    function automatic logic is_legal_switch(riscv::priv_lvl_t priv,
                                             riscv::dmp_domain_t cur,
                                             riscv::dmp_domain_t target);
        logic ok;
        ok = (target != riscv::DOMI);
        if (priv != riscv::PRIV_LVL_M) begin
            ok = ok && ((target & ~cur) == '0);
        end
        return ok;
    endfunction

endpackage

// File: rtl/riscv_pkg.sv
// Minimal riscv package: only the DMP-related types used by the domain
// control stage (domain mask, per-entry config, privilege level).
package riscv;

    typedef logic [7:0] dmp_domain_t;

    // Invalid domain: value of unconfigured entries, never a legal switch target.
    localparam dmp_domain_t DOMI = 8'h00;

    typedef struct packed {
        dmp_domain_t domain;
        logic        locked;
    } dmpcfg_t;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

endpackage

// File: rtl/dmp_domain_ctrl_if.sv
// Switch-request and memory-access handshake between the core and the
// DMP domain control stage.
//
// Handshake semantics:
//   sw_req_i is a level held by the master (with sw_target_i stable) until it
//   sees a one-cycle sw_ack_o or sw_err_o; dropping it earlier does not cancel
//   a switch that is already draining. acc_issue_i may only be raised while
//   acc_ready_o is high; acc_retire_i marks completion of one issued access
//   and is never raised with nothing outstanding.
interface dmp_domain_ctrl_if;

    logic               sw_req_i;
    riscv::dmp_domain_t sw_target_i;
    logic               sw_ack_o;
    logic               sw_err_o;
    logic               acc_issue_i;
    logic               acc_retire_i;
    logic               acc_ready_o;

    modport master (
        output sw_req_i, sw_target_i, acc_issue_i, acc_retire_i,
        input  sw_ack_o, sw_err_o, acc_ready_o
    );

    modport slave (
        input  sw_req_i, sw_target_i, acc_issue_i, acc_retire_i,
        output sw_ack_o, sw_err_o, acc_ready_o
    );

endinterface

// File: rtl/dmp_outstanding_cnt.sv
// Up/down counter of in-flight memory accesses with full/empty flags.
// Overflow/underflow attempts are flagged by assertions and leave the count unchanged.
module dmp_outstanding_cnt #(
    parameter int MAX_OUTSTANDING = 4,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign full_o  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;

    // Next count: simultaneous inc/dec cancel; illegal moves hold.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && !empty_o) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(inc_i && !dec_i && full_o));

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(dec_i && !inc_i && empty_o));

endmodule

// File: rtl/dmp_domain_ctrl.sv
// DMP domain control stage: owns the DMP config array and the current domain,
// sequences safe domain switches (stall, drain, commit, ack) and applies
// lock-respecting CSR writes.
// Optional feature macro: DMP_SWITCH_TIMEOUT_EN (drain timeout aborts a switch).
module dmp_domain_ctrl import dmp_ctrl_pkg::*; #(
    parameter int                 NR_ENTRIES      = 16,
    parameter int                 MAX_OUTSTANDING = 4,
    parameter riscv::dmp_domain_t RESET_DOM       = '1
`ifdef DMP_SWITCH_TIMEOUT_EN
    ,
    parameter int                 SWITCH_TIMEOUT  = 255
`endif
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  riscv::priv_lvl_t         priv_lvl_i,
    input  logic                     csr_we_i,
    input  logic [3:0]               csr_idx_i,
    input  riscv::dmpcfg_t           csr_wdata_i,
    output riscv::dmpcfg_t [15:0]    dmpconf_o,
    output riscv::dmp_domain_t       curdom_o,
    dmp_domain_ctrl_if.slave         ctrl_if,
    output state_e                   dbg_state_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_outstanding_o
);

    state_e                state_q, state_d;
    riscv::dmp_domain_t    curdom_q, curdom_d;
    riscv::dmp_domain_t    target_q, target_d;
    riscv::dmpcfg_t [15:0] dmpconf_q, dmpconf_d;
    logic                  cnt_full, cnt_empty;

`ifdef DMP_SWITCH_TIMEOUT_EN
    localparam int TMR_W = $clog2(SWITCH_TIMEOUT + 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

    dmp_outstanding_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (ctrl_if.acc_issue_i),
        .dec_i  (ctrl_if.acc_retire_i),
        .cnt_o  (dbg_outstanding_o),
        .full_o (cnt_full),
        .empty_o(cnt_empty)
    );

    assign ctrl_if.acc_ready_o = (state_q == IDLE) && !cnt_full;
    assign ctrl_if.sw_ack_o    = (state_q == ACK);
    assign ctrl_if.sw_err_o    = (state_q == ERR);
    assign curdom_o            = curdom_q;
    assign dmpconf_o           = dmpconf_q;
    assign dbg_state_o         = state_q;

    // Switch FSM. The new domain is written on the DRAIN->COMMIT edge so the
    // checker already sees it during COMMIT, one cycle before the ack.
    always_comb begin
        state_d  = state_q;
        curdom_d = curdom_q;
        target_d = target_q;
`ifdef DMP_SWITCH_TIMEOUT_EN
        tmr_d    = tmr_q;
`endif
        case (state_q)
            IDLE: begin
                if (ctrl_if.sw_req_i) begin
                    if (is_legal_switch(priv_lvl_i, curdom_q, ctrl_if.sw_target_i)) begin
                        target_d = ctrl_if.sw_target_i;
                        state_d  = DRAIN;
`ifdef DMP_SWITCH_TIMEOUT_EN
                        tmr_d    = '0;
`endif
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            DRAIN: begin
                if (cnt_empty) begin
                    curdom_d = target_q;
                    state_d  = COMMIT;
                end
`ifdef DMP_SWITCH_TIMEOUT_EN
                else if (tmr_q == TMR_W'(SWITCH_TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
`endif
            end
            COMMIT:  state_d = ACK;
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // CSR write: only implemented, unlocked entries accept new values.
    always_comb begin
        dmpconf_d = dmpconf_q;
        if (csr_we_i && (int'(csr_idx_i) < NR_ENTRIES) && !dmpconf_q[csr_idx_i].locked) begin
            dmpconf_d[csr_idx_i] = csr_wdata_i;
        end
    end

    // State, domain and config registers; unimplemented entries stay at reset value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            curdom_q  <= RESET_DOM;
            target_q  <= RESET_DOM;
            dmpconf_q <= {16{DMP_RST_ENTRY}};
`ifdef DMP_SWITCH_TIMEOUT_EN
            tmr_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            curdom_q <= curdom_d;
            target_q <= target_d;
            for (int i = 0; i < 16; i++) begin
                if (i < NR_ENTRIES) begin
                    dmpconf_q[i] <= dmpconf_d[i];
                end
            end
`ifdef DMP_SWITCH_TIMEOUT_EN
            tmr_q    <= tmr_d;
`endif
        end
    end

endmodule
